// File: rtl/dpll_pkg.sv
// Shared DPLL types: DAC width, midscale code, scheduler FSM states
// and the loop-value clamp helper.
package dpll_pkg;

  localparam int DAC_W = 16;
  localparam logic [DAC_W-1:0] DAC_MID = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    SEND_HI,
    WAIT_HI,
    SEND_LO,
    WAIT_LO,
    GAP
  } state_t;

  function automatic logic [DAC_W-1:0] clamp(
    input logic [DAC_W-1:0] v,
    input logic [DAC_W-1:0] lo,
    input logic [DAC_W-1:0] hi
  );
    logic [DAC_W-1:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/dac_write_scheduler_if.sv
// Byte stream between the DAC write scheduler and the SPI master.
// The master modport is the scheduler side.
interface dac_write_scheduler_if;

  logic [7:0] tx_byte;
  logic       tx_dv;
  logic       tx_ready;

  modport master (
    output tx_byte,
    output tx_dv,
    input  tx_ready
  );

  modport slave (
    input  tx_byte,
    input  tx_dv,
    output tx_ready
  );

endinterface

// File: rtl/dac_write_scheduler_req_slot.sv
// One-deep pending register for a DAC requester: capture, clamp,
// discard/flush and overwrite accounting.
module dac_write_scheduler_req_slot
  import dpll_pkg::*;
#(
  parameter logic [DAC_W-1:0] LO = '0,
  parameter logic [DAC_W-1:0] HI = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dv,
  input  logic [DAC_W-1:0] val,
  input  logic             discard,
  input  logic             flush,
  input  logic             grant,
  output logic             pend,
  output logic [DAC_W-1:0] data,
  output logic [1:0]       ovr
);

  logic             pend_d;
  logic [DAC_W-1:0] data_d;

  // A set in the grant cycle wins and is not an overwrite.
  assign ovr = 2'(dv & discard)
             + 2'(flush & pend & ~grant)
             + 2'(dv & ~discard & pend & ~grant);

  always_comb begin
    pend_d = pend;
    data_d = data;
    if (grant || flush) pend_d = 1'b0;
    if (dv && !discard) begin
      pend_d = 1'b1;
      data_d = clamp(val, LO, HI);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= 1'b0;
      data <= '0;
    end else begin
      pend <= pend_d;
      data <= data_d;
    end
  end

endmodule

// File: rtl/dac_write_scheduler.sv
// Arbitrates manual and loop DAC codes onto one SPI path as
// two-byte frames separated by a fixed idle gap.
module dac_write_scheduler
  import dpll_pkg::*;
#(
  parameter int               GAP_CYCLES = 500,
  parameter logic [DAC_W-1:0] DAC_MIN    = 16'h0000,
  parameter logic [DAC_W-1:0] DAC_MAX    = 16'hFFFF,
  parameter int               CNT_W      = 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic [DAC_W-1:0]     i_Man_Val,
  input  logic                 i_Man_DV,
  input  logic                 i_Man_Mode,
  input  logic [DAC_W-1:0]     i_Loop_Val,
  input  logic                 i_Loop_DV,
  output logic                 o_Man_Ack,
  output logic                 o_Loop_Ack,
  dac_write_scheduler_if.master spi,
  output logic [DAC_W-1:0]     o_DAC_Val,
  output logic                 o_Busy,
  output logic [CNT_W-1:0]     o_Ovr_Count
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t           state, next;
  logic [DAC_W-1:0] frame, man_data, loop_data;
  logic [7:0]       byte_q, tx_byte;
  logic             tx_dv, seen_low, mode_q;
  logic             man_pend, loop_pend;
  logic             man_grant, loop_grant;
  logic [1:0]       man_ovr, loop_ovr;
  logic [GW-1:0]    gap_cnt;
  logic [2:0]       inc;
  logic [CNT_W:0]   sum;

  dac_write_scheduler_req_slot #(
    .LO('0), .HI('1)
  ) u_man (
    .clk(i_Clk), .rst_n(i_Rst_L),
    .dv(i_Man_DV), .val(i_Man_Val),
    .discard(1'b0), .flush(1'b0),
    .grant(man_grant),
    .pend(man_pend), .data(man_data),
    .ovr(man_ovr)
  );

  dac_write_scheduler_req_slot #(
    .LO(DAC_MIN), .HI(DAC_MAX)
  ) u_loop (
    .clk(i_Clk), .rst_n(i_Rst_L),
    .dv(i_Loop_DV), .val(i_Loop_Val),
    .discard(i_Man_Mode),
    .flush(i_Man_Mode & ~mode_q),
    .grant(loop_grant),
    .pend(loop_pend), .data(loop_data),
    .ovr(loop_ovr)
  );

  assign inc = {1'b0, man_ovr} + {1'b0, loop_ovr};
  assign sum = {1'b0, o_Ovr_Count} + (CNT_W + 1)'(inc);

  always_comb begin
    next       = state;
    man_grant  = 1'b0;
    loop_grant = 1'b0;
    tx_dv      = 1'b0;
    tx_byte    = byte_q;
    unique case (state)
      IDLE: if (spi.tx_ready) begin
        if (man_pend) begin
          man_grant = 1'b1;
          next      = SEND_HI;
        end else if (loop_pend && !i_Man_Mode) begin
          loop_grant = 1'b1;
          next       = SEND_HI;
        end
      end
      SEND_HI: begin
        tx_byte = frame[15:8];
        if (spi.tx_ready) begin
          tx_dv = 1'b1;
          next  = WAIT_HI;
        end
      end
      WAIT_HI: if (seen_low && spi.tx_ready) next = SEND_LO;
      SEND_LO: begin
        tx_byte = frame[7:0];
        if (spi.tx_ready) begin
          tx_dv = 1'b1;
          next  = WAIT_LO;
        end
      end
      WAIT_LO: if (seen_low && spi.tx_ready)
        next = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP: if (gap_cnt == GAP_LAST) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      frame       <= '0;
      byte_q      <= '0;
      o_DAC_Val   <= '0;
      o_Ovr_Count <= '0;
      gap_cnt     <= '0;
      seen_low    <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      state  <= next;
      byte_q <= tx_byte;
      mode_q <= i_Man_Mode;
      o_Ovr_Count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      if (man_grant) frame <= man_data;
      else if (loop_grant) frame <= loop_data;
      // Byte done = ready seen low, then high again.
      if (state != next) seen_low <= 1'b0;
      else if (!spi.tx_ready) seen_low <= 1'b1;
      if (state == WAIT_LO && next != WAIT_LO) o_DAC_Val <= frame;
      gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
    end
  end

  assign spi.tx_byte = tx_byte;
  assign spi.tx_dv   = tx_dv;
  assign o_Man_Ack   = man_grant;
  assign o_Loop_Ack  = loop_grant;
  assign o_Busy      = (state != IDLE);

endmodule

// File: tb/tb_dac_write_scheduler.sv
// Scoreboard bench for dac_write_scheduler with a simple SPI master
// model that holds ready low for four clocks per byte.
module tb_dac_write_scheduler;
  import dpll_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_l;
  logic [15:0] man_val, loop_val;
  logic        man_dv, man_mode, loop_dv;
  logic        man_ack, loop_ack;
  logic [15:0] dac_val;
  logic        busy;
  logic [15:0] ovr;

  dac_write_scheduler_if spi ();

  dac_write_scheduler #(
    .GAP_CYCLES(500),
    .DAC_MIN(16'h1000),
    .DAC_MAX(16'hF000),
    .CNT_W(16)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_l),
    .i_Man_Val(man_val),
    .i_Man_DV(man_dv),
    .i_Man_Mode(man_mode),
    .i_Loop_Val(loop_val),
    .i_Loop_DV(loop_dv),
    .o_Man_Ack(man_ack),
    .o_Loop_Ack(loop_ack),
    .spi(spi),
    .o_DAC_Val(dac_val),
    .o_Busy(busy),
    .o_Ovr_Count(ovr)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_bytes[$];
  bit         exp_src[$];
  logic [7:0] mon_b;
  bit         mon_s;
  int         spi_busy;
  int         n;

  // SPI master model
  always @(posedge clk) begin
    if (!rst_l) begin
      spi_busy     <= 0;
      spi.tx_ready <= 1'b1;
    end else if (spi_busy != 0) begin
      spi_busy     <= spi_busy - 1;
      spi.tx_ready <= (spi_busy == 1);
    end else if (spi.tx_dv) begin
      spi_busy     <= 4;
      spi.tx_ready <= 1'b0;
    end
  end

  // Monitor: bytes and acks against the expected queues
  always @(negedge clk) begin
    if (rst_l) begin
      if (spi.tx_dv) begin
        checks++;
        if (!spi.tx_ready) begin
          failures++;
          $display("FAIL tx_dv_ready actual=0 required=1");
        end
        checks++;
        if (exp_bytes.size() == 0) begin
          failures++;
          $display("FAIL tx_byte actual=%h required=none", spi.tx_byte);
        end else begin
          mon_b = exp_bytes.pop_front();
          if (spi.tx_byte !== mon_b) begin
            failures++;
            $display("FAIL tx_byte actual=%h required=%h", spi.tx_byte, mon_b);
          end
        end
      end
      if (man_ack || loop_ack) begin
        checks++;
        if (exp_src.size() == 0 || (man_ack && loop_ack)) begin
          failures++;
          $display("FAIL ack actual=man%0d/loop%0d required=none", man_ack, loop_ack);
        end else begin
          mon_s = exp_src.pop_front();
          if (man_ack !== mon_s) begin
            failures++;
            $display("FAIL ack_src actual=man%0d required=man%0d", man_ack, mon_s);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input bit is_man, input logic [15:0] v);
    exp_src.push_back(is_man);
    exp_bytes.push_back(v[15:8]);
    exp_bytes.push_back(v[7:0]);
  endtask

  task automatic man_pulse(input logic [15:0] v);
    man_val = v;
    man_dv  = 1'b1;
    tick();
    man_dv  = 1'b0;
  endtask

  task automatic loop_pulse(input logic [15:0] v);
    loop_val = v;
    loop_dv  = 1'b1;
    tick();
    loop_dv  = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else if (cnt > 0) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_idle actual=busy%0d required=idle", cnt);
  endtask

  initial begin
    rst_l    = 1'b0;
    man_val  = '0;
    loop_val = '0;
    man_dv   = 1'b0;
    loop_dv  = 1'b0;
    man_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_l = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_dac", dac_val, 0);
    check("rst_ovr", ovr, 0);
    check("rst_tx_dv", spi.tx_dv, 0);
    check("rst_tx_byte", spi.tx_byte, 0);
    check("rst_acks", {man_ack, loop_ack}, 0);

    // manual frame, latency and frame length
    tick();
    expect_frame(1'b1, 16'hA55A);
    man_pulse(16'hA55A);
    @(negedge clk);
    check("man_ack_lat", man_ack, 1);
    check("busy_at_ack", busy, 0);
    @(negedge clk);
    check("tx_dv_lat", spi.tx_dv, 1);
    check("hi_byte", spi.tx_byte, 8'hA5);
    check("dac_before", dac_val, 0);
    wait_idle(n);
    check("busy_rest", n, 511);
    check("dac_a55a", dac_val, 16'hA55A);

    // same-cycle requests: manual first, loop right after gap
    tick();
    expect_frame(1'b1, 16'h1111);
    expect_frame(1'b0, 16'h2222);
    man_val  = 16'h1111;
    loop_val = 16'h2222;
    man_dv   = 1'b1;
    loop_dv  = 1'b1;
    tick();
    man_dv   = 1'b0;
    loop_dv  = 1'b0;
    wait_idle(n);
    check("busy_1111", n, 512);
    check("loop_after_gap", loop_ack, 1);
    wait_idle(n);
    check("busy_2222", n, 512);
    check("dac_2222", dac_val, 16'h2222);
    check("ovr_none", ovr, 0);

    // loop overwrites during an active frame
    tick();
    expect_frame(1'b1, 16'h3C3C);
    expect_frame(1'b0, 16'h1300);
    man_pulse(16'h3C3C);
    repeat (3) tick();
    loop_pulse(16'h1100);
    tick();
    loop_pulse(16'h1200);
    tick();
    loop_pulse(16'h1300);
    wait_idle(n);
    check("loop_grant_ow", loop_ack, 1);
    wait_idle(n);
    check("dac_1300", dac_val, 16'h1300);
    check("ovr_two", ovr, 2);

    // clamp at both ends
    tick();
    expect_frame(1'b0, 16'h1000);
    loop_pulse(16'h0005);
    wait_idle(n);
    check("clamp_lo", dac_val, 16'h1000);
    tick();
    expect_frame(1'b0, 16'hF000);
    loop_pulse(16'hFFFF);
    wait_idle(n);
    check("clamp_hi", dac_val, 16'hF000);

    // loop request discarded in manual mode
    tick();
    man_mode = 1'b1;
    tick();
    loop_pulse(16'h4444);
    repeat (20) tick();
    check("discard_busy", busy, 0);
    check("discard_ovr", ovr, 3);
    check("discard_dac", dac_val, 16'hF000);
    man_mode = 1'b0;

    // manual-mode rise flushes pending loop value
    tick();
    expect_frame(1'b1, 16'h7E7E);
    man_pulse(16'h7E7E);
    repeat (3) tick();
    loop_pulse(16'h5555);
    tick();
    man_mode = 1'b1;
    wait_idle(n);
    check("flush_ovr", ovr, 4);
    repeat (10) tick();
    check("flush_busy", busy, 0);
    check("flush_dac", dac_val, 16'h7E7E);
    man_mode = 1'b0;
    repeat (5) tick();
    check("flush_stays", busy, 0);

    // reset during WAIT_HI
    tick();
    exp_src.push_back(1'b1);
    exp_bytes.push_back(8'hBE);
    man_pulse(16'hBEEF);
    @(negedge clk);
    @(negedge clk);
    check("beef_hi", spi.tx_byte, 8'hBE);
    tick();
    loop_pulse(16'h2000);
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx_dv", spi.tx_dv, 0);
    check("mid_rst_dac", dac_val, 0);
    check("mid_rst_ovr", ovr, 0);
    repeat (30) tick();
    check("mid_rst_idle", busy, 0);
    check("bytes_left", exp_bytes.size(), 0);
    check("acks_left", exp_src.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
